// File: rtl/seq_detector_param_if.sv
// Bit-stream, control and status bundle for the parametrised serial pattern detector.
// The master drives the serial bit and controls; the slave (detector) returns match status.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic [PAT_W-1:0] pattern;
  logic             load;
  logic             overlap;
  logic             cnt_clr;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, din, pattern, load, overlap, cnt_clr,
    input  dout, match_cnt, cnt_sat
  );

  modport slave (
    input  en, din, pattern, load, overlap, cnt_clr,
    output dout, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-loadable PAT_W-bit serial pattern (MSB first),
// with overlap/non-overlap modes, bit-valid gating and a saturating match counter.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1101),
  parameter int               CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  seq_detector_param_if.slave  bus
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic              dout_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sat_r;

  logic [PAT_W-1:0]  hist_n_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              match_s;
  logic [CNT_W-1:0]  cnt_n_s;

  // next history, saturating fill count and match decision for this edge
  always_comb begin
    hist_n_s = {hist_r[PAT_W-2:0], bus.din};
    if (fill_r == FILL_MAX) begin
      fill_inc_s = FILL_MAX;
    end else begin
      fill_inc_s = fill_r + FILL_ONE;
    end
    match_s = bus.en && !bus.load && (fill_inc_s == FILL_MAX) && (hist_n_s == pat_r);
  end

  // next counter value; a match coinciding with cnt_clr still counts once
  always_comb begin
    cnt_n_s = cnt_r;
    if (bus.cnt_clr) begin
      cnt_n_s = match_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (match_s && !(&cnt_r)) begin
      cnt_n_s = cnt_r + CNT_ONE;
    end else begin
      cnt_n_s = cnt_r;
    end
  end

  // pattern, history and match pulse; load restarts detection and wins over en
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pat_r  <= PAT_RST;
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
      dout_r <= 1'b0;
    end else if (bus.load) begin
      pat_r  <= bus.pattern;
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
      dout_r <= 1'b0;
    end else if (bus.en) begin
      hist_r <= hist_n_s;
      dout_r <= match_s;
      if (match_s) begin
        fill_r <= bus.overlap ? FILL_MAX : {FILL_W{1'b0}};
      end else begin
        fill_r <= fill_inc_s;
      end
    end else begin
      dout_r <= 1'b0;
    end
  end

  // match counter and its saturation flag move together
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else begin
      cnt_r <= cnt_n_s;
      sat_r <= &cnt_n_s;
    end
  end

  assign bus.dout      = dout_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cnt_sat   = sat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2): a bit-list reference
// model pushes expected outputs to a scoreboard that is popped after each edge.
module tb_seq_detector_param;

  typedef struct {
    logic       dout;
    logic [1:0] cnt;
    logic       sat;
  } exp_t;

  logic clk;
  logic clr_n;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   pulses = 0;

  exp_t sb[$];

  logic [3:0] m_pat = 4'b1101;
  bit         m_q[$];
  int         m_cnt = 0;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus_if ();

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: keep the sampled bits since the last restart, newest at the back
  task automatic model_edge(input logic e, input logic d, input logic ld,
                            input logic [3:0] p, input logic ov, input logic cc);
    exp_t       x;
    logic       hit;
    logic [3:0] v;
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_q.delete();
    end else if (e) begin
      m_q.push_back(d);
      if (m_q.size() > 4) void'(m_q.pop_front());
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) v[3-i] = m_q[i];
        hit = (v == m_pat);
      end
      if (hit && !ov) m_q.delete();
    end
    if (cc) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 3) m_cnt = m_cnt + 1;
    x.dout = hit;
    x.cnt  = m_cnt[1:0];
    x.sat  = (m_cnt == 3);
    sb.push_back(x);
  endtask

  task automatic step(input logic e, input logic d, input logic ld,
                      input logic [3:0] p, input logic cc, input string tag);
    exp_t x;
    bus_if.en      = e;
    bus_if.din     = d;
    bus_if.load    = ld;
    bus_if.pattern = p;
    bus_if.cnt_clr = cc;
    model_edge(e, d, ld, p, bus_if.overlap, cc);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "_dout"}, 32'(bus_if.dout), 32'(x.dout));
    chk({tag, "_cnt"}, 32'(bus_if.match_cnt), 32'(x.cnt));
    chk({tag, "_sat"}, 32'(bus_if.cnt_sat), 32'(x.sat));
    if (bus_if.dout === 1'b1) pulses++;
    @(negedge clk);
  endtask

  task automatic feed(input string tag, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 4'b0000, 1'b0, tag);
  endtask

  initial begin
    clr_n          = 1'b0;
    bus_if.en      = 1'b0;
    bus_if.din     = 1'b0;
    bus_if.pattern = 4'b0000;
    bus_if.load    = 1'b0;
    bus_if.overlap = 1'b1;
    bus_if.cnt_clr = 1'b0;
    #12;
    chk("rst_dout", 32'(bus_if.dout), 32'd0);
    chk("rst_cnt", 32'(bus_if.match_cnt), 32'd0);
    chk("rst_sat", 32'(bus_if.cnt_sat), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // 1: overlapping, default pattern 1101 on 1101101
    pulses = 0;
    bus_if.overlap = 1'b1;
    feed("t1", 32'b1101101, 7);
    chk("t1_pulses", 32'(pulses), 32'd2);
    chk("t1_cnt_final", 32'(bus_if.match_cnt), 32'd2);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, "t1_clr");

    // 2: non-overlapping, same stream after a restart
    pulses = 0;
    bus_if.overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, "t2_load");
    feed("t2", 32'b1101101, 7);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_cnt_final", 32'(bus_if.match_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, "t2_clr");

    // 3: reload mid-stream discards earlier history
    pulses = 0;
    bus_if.overlap = 1'b1;
    feed("t3_pre", 32'b11, 2);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, "t3_load");
    feed("t3", 32'b0110, 4);
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_cnt_final", 32'(bus_if.match_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, "t3_clr");

    // 4: en gaps are transparent
    pulses = 0;
    step(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, "t4_load");
    feed("t4a", 32'b11, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "t4_gap");
    feed("t4b", 32'b01, 2);
    chk("t4_pulses", 32'(pulses), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, "t4_clr");

    // 5: saturation at 3, then cnt_clr coinciding with a match
    bus_if.overlap = 1'b0;
    for (int k = 0; k < 5; k++) begin
      feed("t5", 32'b1101, 4);
      if (k == 2) chk("t5_sat3", 32'(bus_if.cnt_sat), 32'd1);
    end
    chk("t5_cnt_hold", 32'(bus_if.match_cnt), 32'd3);
    feed("t5_6th", 32'b110, 3);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, "t5_clrmatch");
    chk("t5_clr_cnt", 32'(bus_if.match_cnt), 32'd1);
    chk("t5_clr_sat", 32'(bus_if.cnt_sat), 32'd0);

    // 6: asynchronous reset between edges restores the default pattern
    pulses = 0;
    bus_if.overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, "t6_load");
    feed("t6_pre", 32'b011, 3);
    #1;
    clr_n = 1'b0;
    #1;
    chk("t6_async_dout", 32'(bus_if.dout), 32'd0);
    chk("t6_async_cnt", 32'(bus_if.match_cnt), 32'd0);
    chk("t6_async_sat", 32'(bus_if.cnt_sat), 32'd0);
    m_pat = 4'b1101;
    m_q.delete();
    m_cnt = 0;
    #1;
    clr_n = 1'b1;
    feed("t6", 32'b01101, 5);
    chk("t6_pulses", 32'(pulses), 32'd1);
    chk("t6_cnt_final", 32'(bus_if.match_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore serial pattern detector, replacing the fixed-pattern 4-bit detector in the state-machine library. Detects a runtime-loadable PAT_W-bit pattern (MSB first) on a 1-bit serial input. Supports overlapping and non-overlapping match modes, a clock-enable, and a saturating match counter. Sits between a serial bit source and control/status logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2 to 32.
PAT_RST, 4'b1101 (PAT_W bits), pattern loaded at reset.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous active-low reset
en  input  1  bit-valid; din is sampled only when en=1
din  input  1  serial data bit
pattern  input  PAT_W  new pattern; MSB is the first bit expected
load  input  1  latch pattern and restart detection
overlap  input  1  1=overlapping matches, 0=non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
dout  output  1  registered match pulse (Moore)
match_cnt  output  CNT_W  number of matches, saturating
cnt_sat  output  1  high while match_cnt is all-ones

Behaviour:
- State: pat_q[PAT_W-1:0], hist[PAT_W-1:0] (shift history), fill (0..PAT_W, count of valid history bits), dout, match_cnt.
- Reset (clr_n=0, asynchronous, takes effect immediately):
  - pat_q=PAT_RST, hist=0, fill=0.
  - dout=0, match_cnt=0, cnt_sat=0.
- Priority per rising edge: load > en.
- load=1:
  - pat_q<=pattern, hist<=0, fill<=0, dout<=0.
  - din is ignored that cycle.
  - match_cnt is unaffected, except by cnt_clr.
- en=1, load=0:
  - hist_n={hist[PAT_W-2:0],din}; fill_n=min(fill+1,PAT_W).
  - Match when fill_n==PAT_W and hist_n==pat_q.
  - On match: dout<=1; overlap=1 → fill<=PAT_W; overlap=0 → fill<=0.
  - No match: dout<=0, fill<=fill_n.
  - hist<=hist_n in both cases.
- en=0, load=0: hist and fill hold; dout<=0. Gaps in en are transparent to detection.
- Latency:
  - dout goes high on the same edge that samples the last pattern bit.
  - It stays high for exactly one clk cycle unless the next sampled bit also completes a match.
  - Back-to-back dout=1 is possible only when overlap=1 and the pattern is self-overlapping at shift 1 (e.g. all-ones).
- overlap may change at any time; it is sampled on the match edge only.
- match_cnt:
  - Increments on each edge where dout is set to 1.
  - Holds at 2^CNT_W-1 (no wrap).
  - cnt_sat = (match_cnt == all-ones), registered with the counter.
- cnt_clr=1: match_cnt<=0. If a match occurs on the same edge, match_cnt<=1 (the match is not lost).
- No X propagation: all state is reset. Behaviour for pattern values is defined for every PAT_W-bit value.

Test Plan:
1. Overlap, defaults (1101): overlap=1, en=1, din=1,1,0,1,1,0,1 → dout=1 in the cycles after bit 4 and bit 7 (two one-cycle pulses); match_cnt=2.
2. Non-overlap: overlap=0, same stream 1101101 → single pulse after bit 4; no pulse after bit 7 (fill=3); match_cnt=1.
3. Reload: stream 1,1; load=1 with pattern=4'b0110; then 0,1,1,0 → dout pulse after the final 0 only; the earlier 1,1 did not contribute; match_cnt=1.
4. Enable gaps: din 1,1 with en=1; then 3 cycles en=0 with din=0; then 0,1 with en=1 → exactly one dout pulse after the last 1; dout=0 throughout the gap.
5. Saturation, CNT_W=2, overlap=0: five 1101 patterns → match_cnt 1,2,3,3,3; cnt_sat=1 after the third match. Then cnt_clr on the same edge as a 6th match → match_cnt=1, cnt_sat=0.
6. Async reset mid-operation: after a loaded pattern 0110 and stream 0,1,1, pulse clr_n low between edges → dout, match_cnt and fill are 0 immediately and pat_q=1101. After release, din=0 produces no pulse; a subsequent 1,1,0,1 produces one pulse.
